// File: rtl/noc_output_scheduler_pkg.sv
// Shared types and helpers for the NoC output-port scheduler and its credit counter.
package noc_parameters;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    // Counter must hold the full value CREDITS, hence +1.
    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit tracker: one credit per transferred flit, refilled by credit_return pulses.
module noc_credit_counter
    import noc_parameters::*;
#(
    parameter int CREDITS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              consume,
    input  logic                              credit_return,
    output logic [credit_width(CREDITS)-1:0] count,
    output logic                              available,
    output logic                              ovf
);

    localparam int CW = credit_width(CREDITS);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    // NOTE: asynchronous reset sits in the sensitivity list; every register here gets a reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= FULL;
            ovf   <= 1'b0;
        end else begin
            unique case ({consume, credit_return})
                2'b10: count <= count - 1'b1;
                2'b01: begin
                    if (count == FULL) ovf   <= 1'b1;
                    else               count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // No bypass: a returned credit becomes usable only after it is registered.
    assign available = (count != '0);

endmodule

// File: rtl/noc_output_scheduler.sv
// Wormhole output-port scheduler: round-robin on head flits, locks to the winner until its tail,
// and gates every grant on downstream credit.
module noc_output_scheduler
    import noc_parameters::*;
#(
    parameter int REQUESTS = 4,
    parameter int CREDITS  = 4
) (
    input  logic                              noc_clk,
    input  logic                              noc_rst,
    input  logic [REQUESTS-1:0]               req_valid,
    input  logic [REQUESTS-1:0]               req_head,
    input  logic [REQUESTS-1:0]               req_tail,
    output logic [REQUESTS-1:0]               grant,
    output logic                              out_valid,
    output logic [$clog2(REQUESTS)-1:0]       out_sel,
    input  logic                              credit_return,
    output logic [credit_width(CREDITS)-1:0] credit_count,
    output logic                              locked,
    output logic                              err_credit_ovf
);

    localparam int SW = $clog2(REQUESTS);
    localparam logic [SW-1:0] LAST_RESET = SW'(REQUESTS - 1);

    sched_state_e   state;
    logic [SW-1:0]  owner;
    logic [SW-1:0]  last_winner;
    logic [SW-1:0]  pick;
    logic [SW-1:0]  sel;
    logic           available;
    logic           transfer;

    // First set bit strictly after `last`, searching circularly upward.
    function automatic logic [SW-1:0] rr_pick(input logic [REQUESTS-1:0] cand,
                                               input logic [SW-1:0]       last);
        logic [SW-1:0] w;
        logic [SW-1:0] j;
        w = '0;
        for (int i = REQUESTS; i >= 1; i--) begin
            j = SW'((int'(last) + i) % REQUESTS);
            if (cand[j]) w = j;
        end
        return w;
    endfunction

    // NOTE: combinational blocks use blocking assignments and default every output first, so no latch is inferred.
    always_comb begin
        grant = '0;
        sel   = '0;
        pick  = rr_pick(req_valid & req_head, last_winner);
        if (!noc_rst && available) begin
            if (state == IDLE) begin
                if (|(req_valid & req_head)) begin
                    sel         = pick;
                    grant[pick] = 1'b1;
                end
            end else if (req_valid[owner]) begin
                sel          = owner;
                grant[owner] = 1'b1;
            end
        end
    end

    assign out_valid = |grant;
    assign out_sel   = sel;
    assign transfer  = out_valid;
    assign locked    = (state == LOCKED);

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state       <= IDLE;
            owner       <= '0;
            last_winner <= LAST_RESET;
        end else if (transfer) begin
            if (state == IDLE) begin
                last_winner <= sel;
                if (!req_tail[sel]) begin
                    state <= LOCKED;
                    owner <= sel;
                end
            end else if (req_tail[owner]) begin
                state <= IDLE;
            end
        end
    end

    noc_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk           (noc_clk),
        .rst           (noc_rst),
        .consume       (transfer),
        .credit_return (credit_return),
        .count         (credit_count),
        .available     (available),
        .ovf           (err_credit_ovf)
    );

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Directed and randomized checks of noc_output_scheduler against a cycle-level behavioural model.
module tb_noc_output_scheduler;

    localparam int R = 4;
    localparam int C = 4;

    logic       noc_clk;
    logic       noc_rst;
    logic [3:0] req_valid, req_head, req_tail;
    logic       credit_return;

    logic [3:0] grant, grant2;
    logic       out_valid, out_valid2;
    logic [1:0] out_sel, out_sel2;
    logic [2:0] credit_count;
    logic [1:0] credit_count2;
    logic       locked, locked2;
    logic       err_credit_ovf, err_credit_ovf2;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit m_locked;
    int m_owner;
    int m_last;
    int m_cred;
    bit m_ovf;

    noc_output_scheduler #(.REQUESTS(R), .CREDITS(C)) dut (
        .noc_clk        (noc_clk),
        .noc_rst        (noc_rst),
        .req_valid      (req_valid),
        .req_head       (req_head),
        .req_tail       (req_tail),
        .grant          (grant),
        .out_valid      (out_valid),
        .out_sel        (out_sel),
        .credit_return  (credit_return),
        .credit_count   (credit_count),
        .locked         (locked),
        .err_credit_ovf (err_credit_ovf)
    );

    noc_output_scheduler #(.REQUESTS(R), .CREDITS(2)) dut2 (
        .noc_clk        (noc_clk),
        .noc_rst        (noc_rst),
        .req_valid      (req_valid),
        .req_head       (req_head),
        .req_tail       (req_tail),
        .grant          (grant2),
        .out_valid      (out_valid2),
        .out_sel        (out_sel2),
        .credit_return  (credit_return),
        .credit_count   (credit_count2),
        .locked         (locked2),
        .err_credit_ovf (err_credit_ovf2)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = R - 1;
        m_cred   = C;
        m_ovf    = 1'b0;
    endtask

    // Assert reset at a negedge, check outputs immediately, release at the following negedge.
    task automatic apply_reset(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t);
        @(negedge noc_clk);
        noc_rst = 1'b1;
        req_valid = v; req_head = h; req_tail = t; credit_return = 1'b0;
        #1;
        model_reset();
        check("rst_grant",     32'(grant),          32'd0);
        check("rst_out_valid", 32'(out_valid),      32'd0);
        check("rst_out_sel",   32'(out_sel),        32'd0);
        check("rst_locked",    32'(locked),         32'd0);
        check("rst_credits",   32'(credit_count),   32'(C));
        check("rst_ovf",       32'(err_credit_ovf), 32'd0);
        check("rst_credits2",  32'(credit_count2),  32'd2);
        @(negedge noc_clk);
        noc_rst = 1'b0;
    endtask

    // Drive one cycle of inputs, compare against the model, then advance the model.
    task automatic cycle(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t, input logic cr);
        bit found;
        int esel;
        int eg;
        @(negedge noc_clk);
        req_valid = v; req_head = h; req_tail = t; credit_return = cr;
        #1;
        found = 1'b0;
        esel  = 0;
        if (m_cred > 0) begin
            if (!m_locked) begin
                for (int k = 1; k <= R; k++) begin
                    int idx;
                    idx = (m_last + k) % R;
                    if (!found && v[idx] && h[idx]) begin
                        found = 1'b1;
                        esel  = idx;
                    end
                end
            end else if (v[m_owner]) begin
                found = 1'b1;
                esel  = m_owner;
            end
        end
        eg = found ? (1 << esel) : 0;
        check("grant",     32'(grant),          32'(eg));
        check("out_valid", 32'(out_valid),      32'(found));
        check("out_sel",   32'(out_sel),        32'(esel));
        check("credits",   32'(credit_count),   32'(m_cred));
        check("locked",    32'(locked),         32'(m_locked));
        check("ovf",       32'(err_credit_ovf), 32'(m_ovf));
        if (found) begin
            if (!m_locked) begin
                m_last = esel;
                if (!t[esel]) begin
                    m_locked = 1'b1;
                    m_owner  = esel;
                end
            end else if (t[esel]) begin
                m_locked = 1'b0;
            end
        end
        if (found && !cr) begin
            m_cred--;
        end else if (!found && cr) begin
            if (m_cred == C) m_ovf = 1'b1;
            else             m_cred++;
        end
    endtask

    initial begin
        noc_rst = 1'b1;
        req_valid = '0; req_head = '0; req_tail = '0; credit_return = 1'b0;
        model_reset();
        apply_reset(4'b0000, 4'b0000, 4'b0000);

        // Alternating single-flit packets from inputs 0 and 2 drain the credits.
        cycle(4'b0101, 4'b0101, 4'b0101, 1'b0);
        check("t1_g0", 32'(grant), 32'b0001);
        check("t1_c2_g0", 32'(grant2), 32'b0001);
        cycle(4'b0101, 4'b0101, 4'b0101, 1'b0);
        check("t1_g1", 32'(grant), 32'b0100);
        cycle(4'b0101, 4'b0101, 4'b0101, 1'b0);
        check("t1_g2", 32'(grant), 32'b0001);
        check("c2_starved_grant", 32'(grant2), 32'd0);
        check("c2_starved_count", 32'(credit_count2), 32'd0);
        cycle(4'b0101, 4'b0101, 4'b0101, 1'b0);
        check("t1_g3", 32'(grant), 32'b0100);
        // Credit return with no bypass, then grant one cycle later.
        cycle(4'b0101, 4'b0101, 4'b0101, 1'b1);
        check("t1_empty_count", 32'(credit_count), 32'd0);
        check("c2_nobypass", 32'(grant2), 32'd0);
        cycle(4'b0101, 4'b0101, 4'b0101, 1'b0);
        check("c2_return_grant", 32'(grant2), 32'b0001);
        check("c2_return_count", 32'(credit_count2), 32'd1);
        cycle(4'b0101, 4'b0101, 4'b0101, 1'b0);
        check("c2_after_count", 32'(credit_count2), 32'd0);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Three-flit packet from input 1 while input 2 keeps a single-flit head waiting.
        cycle(4'b0110, 4'b0110, 4'b0100, 1'b0);
        check("t2_head", 32'(grant), 32'b0010);
        cycle(4'b0110, 4'b0100, 4'b0100, 1'b0);
        check("t2_body_locked", 32'(locked), 32'd1);
        cycle(4'b0110, 4'b0100, 4'b0110, 1'b0);
        check("t2_tail", 32'(grant), 32'b0010);
        cycle(4'b0100, 4'b0100, 4'b0100, 1'b0);
        check("t2_next_head", 32'(grant), 32'b0100);
        for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Owner bubble: lock held, competing heads ignored.
        cycle(4'b0010, 4'b0010, 4'b0000, 1'b0);
        cycle(4'b1100, 4'b1100, 4'b1100, 1'b1);
        check("t3_bubble_grant", 32'(grant), 32'd0);
        cycle(4'b1100, 4'b1100, 4'b1100, 1'b0);
        check("t3_bubble_locked", 32'(locked), 32'd1);
        cycle(4'b0010, 4'b0000, 4'b0010, 1'b0);

        // Simultaneous transfer and return, then overflow.
        cycle(4'b0001, 4'b0001, 4'b0001, 1'b1);
        cycle(4'b0000, 4'b0000, 4'b0000, 1'b1);
        check("t5_simul_count", 32'(credit_count), 32'd3);
        cycle(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check("t5_ovf_set", 32'(err_credit_ovf), 32'd1);
        cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Reset mid-packet drops the lock; an old body flit is not granted.
        cycle(4'b0010, 4'b0010, 4'b0000, 1'b0);
        apply_reset(4'b0010, 4'b0000, 4'b0000);
        cycle(4'b0010, 4'b0000, 4'b0000, 1'b0);
        check("t6_body_blocked", 32'(grant), 32'd0);
        cycle(4'b1010, 4'b1000, 4'b1000, 1'b0);
        check("t6_head3", 32'(grant), 32'b1000);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] v, h, t;
            logic       cr;
            v  = 4'($urandom);
            h  = 4'($urandom);
            t  = 4'($urandom);
            cr = ($urandom_range(0, 2) == 0);
            cycle(v, h, t, cr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/noc_output_scheduler.md
# noc_output_scheduler

Per-output-port wormhole scheduler for the NoC router crossbar. It shares one output port among REQUESTS input ports with round-robin fairness. Once a packet's head flit wins, the port stays locked to that input until the tail flit transfers. It also tracks downstream buffer credits, so a flit is only granted when the next hop has room. One instance sits at each router output, between the input buffers and the crossbar select.

## Interface
Parameters:
- REQUESTS, 4, number of input ports competing for this output (≥2).
- CREDITS, 4, downstream buffer depth; the credit counter resets to this value (≥1).

Ports:
- noc_clk  in  1  router clock; single clock domain.
- noc_rst  in  1  asynchronous, active-high reset.
- req_valid  in  REQUESTS  bit i: input i has a flit at its buffer head routed to this output.
- req_head  in  REQUESTS  bit i: that flit is a head flit (qualified by req_valid[i]).
- req_tail  in  REQUESTS  bit i: that flit is a tail flit. Head and tail together mark a single-flit packet.
- grant  out  REQUESTS  one-hot or zero; bit i means input i's flit crosses the switch this cycle (input pops).
- out_valid  out  1  equals |grant.
- out_sel  out  $clog2(REQUESTS)  index of the granted input; 0 when out_valid=0.
- credit_return  in  1  one-cycle pulse; downstream freed one slot.
- credit_count  out  $clog2(CREDITS+1)  current credits.
- locked  out  1  high while state is LOCKED.
- err_credit_ovf  out  1  sticky; set by credit_return while credit_count==CREDITS.

## Operation
- States:
  - IDLE: no packet owns the port.
  - LOCKED: owner register holds the input index.
- Credit gate: a grant requires credit_count != 0. There is no same-cycle bypass from credit_return.
- IDLE:
  - Candidates are req_valid & req_head; non-head flits are never granted in IDLE.
  - If there is a candidate and credit is available, choose the first candidate after last_winner, searching circularly upward.
  - Grant the winner this cycle and set last_winner to the winner.
  - If the winner's req_tail=1, stay in IDLE. Otherwise go to LOCKED with owner = winner.
- LOCKED:
  - grant = onehot(owner) iff req_valid[owner] and credit is available. All other inputs get 0.
  - req_head from the owner is ignored and the flit is treated as a body flit.
  - A granted flit with req_tail[owner]=1 returns the state to IDLE. last_winner is unchanged.
  - While locked, a missing owner flit (bubble) or zero credits stall with no grant; the lock is held.
- Credits:
  - Transfer only: decrement.
  - credit_return only: increment, saturating at CREDITS, and set err_credit_ovf if already at CREDITS.
  - Transfer and credit_return in the same cycle: count unchanged.
- Width rule: credit_count never wraps below 0, because grant is gated on count != 0.

## Timing
- grant, out_valid and out_sel are combinational from the registered state plus req_* and credit_count. Grant latency is 0 cycles.
- The state, owner, last_winner, credit_count and err_credit_ovf registers update on the posedge of noc_clk.
- Reset values (asynchronous, taking effect immediately on noc_rst=1):
  - state = IDLE, locked = 0, owner = 0.
  - last_winner = REQUESTS-1, so input 0 has top priority.
  - credit_count = CREDITS, err_credit_ovf = 0.
  - Resulting outputs: grant = 0 (while reset is held), out_valid = 0, out_sel = 0.
- Reset mid-packet drops the lock. The first grant after release requires a head flit.
- A credit_return arriving at cycle t makes that credit usable from cycle t+1.
- Back-to-back packets are supported:
  - A tail grant in cycle t allows a new head grant in cycle t+1.
  - In IDLE, a head+tail flit can be granted every cycle, given credits.

## Structure
- Noc_parameters package provides:
  - the sched_state_e typedef {IDLE, LOCKED};
  - a function returning the credit width, $clog2(CREDITS+1).
- Sub-module noc_credit_counter: parameter CREDITS; inputs consume and credit_return; outputs count, available and ovf. It is reusable by the input-side VC logic.
- Round-robin pick: a local function with circular priority starting at last_winner+1.

## Test plan
- Reset, then req_valid=4'b0101 with head and tail set on both, held for 4 cycles: grants 0001, 0100, 0001, 0100; credit_count goes 4→0.
- Input 1 sends a 3-flit packet while input 2 requests a head throughout: grant=0010 for 3 cycles with locked=1, then grant=0100 in the 4th cycle.
- Owner bubble: input 1 is locked and its req_valid drops for 2 cycles: grant=0 and locked stays 1; other heads are not granted.
- CREDITS=2, no returns: after 2 transfers grant=0 with requests pending. A credit_return pulse at cycle t gives a grant at t+1 and count goes 1→0.
- Simultaneous transfer and credit_return at count=3: count stays 3. A credit_return at count=4 sets err_credit_ovf=1, which stays set until reset.
- Assert noc_rst mid-packet: locked=0 and count=4 immediately. After release, a body flit from the old owner is not granted; a head from input 3 is granted.
